// File: rtl/fir_sched_pkg.sv
// Shared state encoding, default sizing and width helpers for the FIR MAC
// scheduler and its round-robin arbiter.
package fir_sched_pkg;

   localparam int DEF_NCH   = 4;
   localparam int DEF_ORDER = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

   function automatic int chan_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   function automatic int tap_w(input int order);
      return (order > 0) ? $clog2(order + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found after
// last_grant, wrapping NCH-1 -> 0.
module rr_arbiter
   import fir_sched_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int CW  = chan_w(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  last_grant,
   output logic           grant_valid,
   output logic [NCH-1:0] grant,
   output logic [CW-1:0]  grant_idx
);

   logic [CW:0]   cand;
   logic [CW-1:0] idx;

   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      grant_idx   = '0;
      cand        = '0;
      idx         = '0;
      // Visit last_grant+1 .. last_grant+NCH; the extra bit keeps the modulo exact.
      for (int i = 1; i <= NCH; i++) begin
         cand = {1'b0, last_grant} + (CW+1)'(i);
         if (cand >= (CW+1)'(NCH)) begin
            cand = cand - (CW+1)'(NCH);
         end
         idx = cand[CW-1:0];
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant[idx]  = 1'b1;
            grant_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Shares one sequential FIR MAC datapath among NCH channels: grant, step taps,
// shift the delay line, then hold the result until the consumer takes it.
module fir_mac_scheduler
   import fir_sched_pkg::*;
#(
   parameter int NCH   = DEF_NCH,
   parameter int ORDER = DEF_ORDER,
   parameter int CW    = chan_w(NCH),
   parameter int TW    = tap_w(ORDER)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] req_valid,
   output logic [NCH-1:0] req_ready,
   output logic [CW-1:0]  dp_chan,
   output logic           dp_load,
   output logic           dp_mac_en,
   output logic           dp_mac_first,
   output logic [TW-1:0]  dp_tap,
   output logic           dp_shift,
   output logic           res_valid,
   output logic [CW-1:0]  res_chan,
   input  logic           res_ready,
   output logic           busy
);

   // Handshakes: a transfer happens in a cycle where valid and ready are both 1;
   // valid never waits on ready, and res_valid/res_chan stay fixed until taken.

   localparam logic [TW-1:0] LAST_TAP  = TW'(ORDER);
   localparam logic [CW-1:0] LAST_CHAN = CW'(NCH - 1);

   sched_state_e  state_q, state_d;
   logic [TW-1:0] tap_q, tap_d;
   logic [CW-1:0] chan_q, chan_d;
   logic [CW-1:0] last_grant_q, last_grant_d;

   logic           arb_valid;
   logic [NCH-1:0] arb_grant;
   logic [CW-1:0]  arb_idx;

   rr_arbiter #(
      .NCH (NCH),
      .CW  (CW)
   ) u_arb (
      .req         (req_valid),
      .last_grant  (last_grant_q),
      .grant_valid (arb_valid),
      .grant       (arb_grant),
      .grant_idx   (arb_idx)
   );

   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      chan_d       = chan_q;
      last_grant_d = last_grant_q;
      req_ready    = '0;
      dp_load      = 1'b0;
      dp_mac_en    = 1'b0;
      dp_mac_first = 1'b0;
      dp_shift     = 1'b0;
      res_valid    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               req_ready    = arb_grant;
               dp_load      = 1'b1;
               chan_d       = arb_idx;
               last_grant_d = arb_idx;
               tap_d        = '0;
               state_d      = MAC;
            end
         end
         MAC: begin
            dp_mac_en    = 1'b1;
            dp_mac_first = (tap_q == '0);
            // The tap index parks at ORDER; it is cleared on the next accept.
            if (tap_q == LAST_TAP) begin
               state_d = SHIFT;
            end else begin
               tap_d = tap_q + TW'(1);
            end
         end
         SHIFT: begin
            dp_shift = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         tap_q        <= '0;
         chan_q       <= '0;
         last_grant_q <= LAST_CHAN;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         chan_q       <= chan_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign dp_chan  = chan_q;
   assign res_chan = chan_q;
   assign dp_tap   = tap_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

Sequencer and round-robin arbiter that shares one sequential multiply-accumulate FIR datapath among NCH sample channels. Per accepted sample it grants one channel, steps the tap index through the coefficient/delay-line MAC sequence, and commands the delay-line shift. It then holds the finished result until the consumer takes it. It sits between the per-channel sample sources and the shared FIR MAC datapath, which holds coefficients, per-channel delay lines and the accumulator.

## Interface
Parameters:
- NCH, 4: number of requesting channels (≥2).
- ORDER, 8: filter order; taps = ORDER+1, indexed 0..ORDER.
- CW, $clog2(NCH): channel index width.
- TW, $clog2(ORDER+1): tap index width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NCH  per-channel "sample available".
- req_ready  out  NCH  one-hot accept; combinational, nonzero only in IDLE.
- dp_chan  out  CW  channel whose delay line/result the datapath uses.
- dp_load  out  1  datapath captures the granted channel's input sample (accept cycle).
- dp_mac_en  out  1  accumulate c[dp_tap]·x[dp_tap] this cycle.
- dp_mac_first  out  1  with dp_mac_en: sum = c[0]·sample (clear-and-load accumulator).
- dp_tap  out  TW  current tap index.
- dp_shift  out  1  shift granted channel's delay line: i[j]←i[j-1] for j≥1, then i[0]←sample.
- res_valid  out  1  accumulator holds final result for res_chan.
- res_chan  out  CW  channel of pending result (= dp_chan).
- res_ready  in  1  consumer accepts result.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, MAC, SHIFT, DONE.
- IDLE:
  - If any req_valid, the arbiter picks the first set bit searching from last_grant+1 (mod NCH).
  - req_ready[g]=1 and dp_load=1 in the same cycle. dp_chan=g is latched.
  - tap←0, last_grant←g, next state MAC.
  - With no req_valid, stay in IDLE with all strobes 0.
- MAC: dp_mac_en=1 for every tap 0..ORDER.
  - dp_mac_first=1 only at tap 0.
  - tap increments each cycle. At tap==ORDER the next state is SHIFT.
- SHIFT: dp_shift=1 for exactly one cycle, then DONE.
- DONE: res_valid=1 and held stable, with res_chan stable, until res_ready=1.
  - The cycle with res_valid&res_ready completes the transfer and the next state is IDLE.
  - A new grant occurs no earlier than the following cycle.
- Fairness: a channel continuously requesting is granted at least once per NCH transactions.
- The scheduler never drops or reorders: one grant yields exactly one result on the same channel.
- In IDLE, dp_chan holds the last granted channel.

## Timing
- Reset values:
  - state=IDLE, tap=0, dp_chan=0, last_grant=NCH-1 (channel 0 is first priority).
  - req_ready=0, dp_load=0, dp_mac_en=0, dp_mac_first=0, dp_shift=0, res_valid=0, res_chan=0, busy=0.
- All outputs except req_ready/dp_load are registered or purely state-decoded. req_ready/dp_load depend combinationally on req_valid in IDLE.
- If accept is in cycle t0:
  - MAC runs in cycles t0+1..t0+ORDER+1.
  - SHIFT runs in t0+ORDER+2.
  - res_valid first rises in t0+ORDER+3 (11 for ORDER=8).
- Minimum accept-to-accept spacing is ORDER+4 cycles, with res_ready tied high.
- tap counter width is TW and never exceeds ORDER. There is no wrap-around beyond ORDER.
- last_grant wraps NCH-1 → 0.
- A reset asserted in any state returns to the reset values on the next edge. The in-flight result is discarded. The datapath is not shifted unless dp_shift was already issued.
- res_ready asserted outside DONE is ignored.
- req_valid deasserting during MAC/SHIFT/DONE is ignored, since the sample was captured at dp_load.

## Structure
- Package fir_sched_pkg holds:
  - the state enum (IDLE, MAC, SHIFT, DONE);
  - default NCH/ORDER constants;
  - helper functions for CW/TW.
- One sub-module, rr_arbiter (NCH requests, last_grant pointer in, one-hot grant + encoded index out, combinational). It is reused by other shared-resource controllers.
- The FSM, tap counter and output decode live in fir_mac_scheduler.

## Test plan
- Reset then idle: no req_valid for 20 cycles → every strobe 0, busy=0. Assert reset mid-MAC at tap 4 → next cycle is IDLE with all outputs at reset values and no dp_shift.
- Single channel: req_valid=4'b0100 at t0 → req_ready=4'b0100 and dp_load at t0. dp_mac_en at t1..t9 with dp_tap 0..8 and dp_mac_first only at t1. dp_shift at t10. res_valid at t11 with res_chan=2.
- Round-robin: req_valid=4'b1111 held with res_ready=1 → grant order 0,1,2,3,0, with each accept exactly 12 cycles apart.
- Backpressure: res_ready=0 for 7 cycles in DONE → res_valid and res_chan stable. No new req_ready until the cycle after res_ready=1.
- Skipping and wrap: last_grant=3, req_valid=4'b0101 → grant 0, then grant 2, then grant 0.
- Against a reference FIR model with ORDER=8: impulse on channel 1 interleaved with ramp on channel 3 → per-channel outputs match the model. The channels' delay lines never mix.
